// File: rtl/reg_file_scoreboard_pkg.sv
// rtl/reg_file_scoreboard_pkg.sv - shared width/depth defaults and register-0 index
package reg_file_scoreboard_pkg;

    localparam int DEF_BITS  = 64;
    localparam int DEF_NREGS = 32;
    localparam int REG_ZERO  = 0;

endpackage

// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - one read port: index decode, zero forcing, write bypass, busy lookup
module reg_read_port
    import reg_file_scoreboard_pkg::*;
#(
    parameter int  BITS   = DEF_BITS,
    parameter int  NREGS  = DEF_NREGS,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                       reset,
    input  logic [AW-1:0]              raddr,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic [BITS-1:0]            wdata,
    input  logic [NREGS-1:0][BITS-1:0] regs,
    input  logic [NREGS-1:0]           busy,
    output logic [BITS-1:0]            rdata,
    output logic                       rbusy
);

    logic hit;
    logic zero_idx;

    // Bypass is suppressed during reset so reads stay at zero even if we is high.
    assign hit      = (BYPASS != 0) && we && !reset && (waddr == raddr);
    assign zero_idx = (raddr == AW'(REG_ZERO));

    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (!reset && !zero_idx) begin
            rdata = hit ? wdata : regs[raddr];
            rbusy = busy[raddr] && !hit;
        end
    end

endmodule

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - register file with per-register busy scoreboard and NREAD read ports
module reg_file_scoreboard
    import reg_file_scoreboard_pkg::*;
#(
    parameter int  BITS   = DEF_BITS,
    parameter int  NREGS  = DEF_NREGS,
    parameter int  NREAD  = 2,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [BITS-1:0]       wdata,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*BITS-1:0] rdata,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  set_busy,
    input  logic [AW-1:0]         set_addr,
    input  logic                  flush
);

    logic [NREGS-1:0][BITS-1:0] regs;
    logic [NREGS-1:0]           busy;
    logic                       wr_en;
    logic                       set_en;

    assign wr_en  = we && (waddr != AW'(REG_ZERO));
    assign set_en = set_busy && (set_addr != AW'(REG_ZERO));

    // Set is applied after clear so a new producer on the same index wins; flush beats both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
            busy <= '0;
        end else begin
            if (wr_en) regs[waddr] <= wdata;
            if (flush) begin
                busy <= '0;
            end else begin
                if (wr_en)  busy[waddr]    <= 1'b0;
                if (set_en) busy[set_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        reg_read_port #(
            .BITS   (BITS),
            .NREGS  (NREGS),
            .BYPASS (BYPASS)
        ) u_port (
            .reset  (reset),
            .raddr  (raddr[i*AW +: AW]),
            .we     (we),
            .waddr  (waddr),
            .wdata  (wdata),
            .regs   (regs),
            .busy   (busy),
            .rdata  (rdata[i*BITS +: BITS]),
            .rbusy  (rbusy[i])
        );
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - self-checking bench for reg_file_scoreboard (default and narrow no-bypass builds)
module tb_reg_file_scoreboard;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         we = 1'b0;
    logic [4:0]   waddr = '0;
    logic [63:0]  wdata = '0;
    logic [9:0]   raddr = '0;
    logic [127:0] rdata;
    logic [1:0]   rbusy;
    logic         set_busy = 1'b0;
    logic [4:0]   set_addr = '0;
    logic         flush = 1'b0;

    logic [3:0]   waddr2;
    logic [31:0]  wdata2;
    logic [11:0]  raddr2;
    logic [95:0]  rdata2;
    logic [2:0]   rbusy2;
    logic [3:0]   set_addr2;

    int compared = 0;
    int mismatched = 0;

    logic [63:0] m_regs  [32];
    logic        m_busy  [32];
    logic [31:0] m2_regs [16];
    logic        m2_busy [16];

    always #5 clk = ~clk;

    assign waddr2    = waddr[3:0];
    assign wdata2    = wdata[31:0];
    assign set_addr2 = set_addr[3:0];

    reg_file_scoreboard dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .set_busy (set_busy),
        .set_addr (set_addr),
        .flush    (flush)
    );

    reg_file_scoreboard #(.BITS(32), .NREGS(16), .NREAD(3), .BYPASS(0)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr2),
        .wdata    (wdata2),
        .raddr    (raddr2),
        .rdata    (rdata2),
        .rbusy    (rbusy2),
        .set_busy (set_busy),
        .set_addr (set_addr2),
        .flush    (flush)
    );

    task automatic apply(input logic r, input logic w, input logic [4:0] wa, input logic [63:0] wd,
                         input logic s, input logic [4:0] sa, input logic f,
                         input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2);
        reset    = r;
        we       = w;
        waddr    = wa;
        wdata    = wd;
        set_busy = s;
        set_addr = sa;
        flush    = f;
        raddr    = {ra1, ra0};
        raddr2   = {ra2[3:0], ra1[3:0], ra0[3:0]};
        #2;
    endtask

    // Reference model advances on each rising edge from the stimulus currently applied.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
            for (int i = 0; i < 16; i++) begin m2_regs[i] = '0; m2_busy[i] = 1'b0; end
        end else begin
            if (we && waddr != 0)      m_regs[waddr] = wdata;
            if (we && waddr[3:0] != 0) m2_regs[waddr[3:0]] = wdata[31:0];
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
                for (int i = 0; i < 16; i++) m2_busy[i] = 1'b0;
            end else begin
                if (we && waddr != 0)            m_busy[waddr] = 1'b0;
                if (set_busy && set_addr != 0)   m_busy[set_addr] = 1'b1;
                if (we && waddr[3:0] != 0)       m2_busy[waddr[3:0]] = 1'b0;
                if (set_busy && set_addr[3:0] != 0) m2_busy[set_addr[3:0]] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) begin
            apply(1, 1, 5'(i), {$urandom, $urandom}, 1, 5'(i), 1, 5'(i), 5'(i), 5'(i));
            compared++;
            if (rdata !== '0 || rbusy !== '0) begin
                mismatched++;
                $display("FAIL reset_hold idx=%0d got rdata=%h rbusy=%b expected 0/0", i, rdata, rbusy);
            end
            compared++;
            if (rdata2 !== '0 || rbusy2 !== '0) begin
                mismatched++;
                $display("FAIL reset_hold_narrow idx=%0d got rdata=%h rbusy=%b expected 0/0", i, rdata2, rbusy2);
            end
            step();
        end
        for (int i = 0; i < 32; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i));
            compared++;
            if (rdata !== '0 || rbusy !== '0) begin
                mismatched++;
                $display("FAIL reset_read idx=%0d got rdata=%h rbusy=%b expected 0/0", i, rdata, rbusy);
            end
            compared++;
            if (rdata2 !== '0 || rbusy2 !== '0) begin
                mismatched++;
                $display("FAIL reset_read_narrow idx=%0d got rdata=%h rbusy=%b expected 0/0", i, rdata2, rbusy2);
            end
            step();
        end
    endtask

    task automatic test_bypass();
        apply(0, 1, 5, 64'hDEADBEEF_00000001, 0, 0, 0, 5, 5, 5);
        compared++;
        if (rdata !== {2{64'hDEADBEEF_00000001}}) begin
            mismatched++;
            $display("FAIL bypass_same_cycle got %h expected %h on both ports", rdata, 64'hDEADBEEF_00000001);
        end
        compared++;
        if (rdata2 !== '0) begin
            mismatched++;
            $display("FAIL nobypass_same_cycle got %h expected 0", rdata2);
        end
        step();
        apply(0, 0, 0, 0, 0, 0, 0, 5, 5, 5);
        compared++;
        if (rdata[63:0] !== 64'hDEADBEEF_00000001) begin
            mismatched++;
            $display("FAIL bypass_next_cycle got %h expected DEADBEEF00000001", rdata[63:0]);
        end
        compared++;
        if (rdata2 !== {3{32'h0000_0001}}) begin
            mismatched++;
            $display("FAIL nobypass_next_cycle got %h expected 00000001 on all ports", rdata2);
        end
        step();
    endtask

    task automatic test_zero();
        apply(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 0, 0);
        compared++;
        if (rdata !== '0 || rbusy !== '0 || rdata2 !== '0 || rbusy2 !== '0) begin
            mismatched++;
            $display("FAIL x0_same_cycle got %h/%b %h/%b expected all 0", rdata, rbusy, rdata2, rbusy2);
        end
        step();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        compared++;
        if (rdata !== '0 || rbusy !== '0 || rdata2 !== '0 || rbusy2 !== '0) begin
            mismatched++;
            $display("FAIL x0_after got %h/%b %h/%b expected all 0", rdata, rbusy, rdata2, rbusy2);
        end
        step();
    endtask

    task automatic test_busy_latency();
        apply(0, 0, 0, 0, 1, 7, 0, 7, 7, 7);
        compared++;
        if (rbusy !== 2'b00 || rbusy2 !== 3'b000) begin
            mismatched++;
            $display("FAIL busy_cycle_n got %b/%b expected 00/000", rbusy, rbusy2);
        end
        step();
        apply(0, 0, 0, 0, 0, 0, 0, 7, 7, 7);
        compared++;
        if (rbusy !== 2'b11 || rbusy2 !== 3'b111) begin
            mismatched++;
            $display("FAIL busy_cycle_n1 got %b/%b expected 11/111", rbusy, rbusy2);
        end
        step();
        step();
        apply(0, 1, 7, 64'h77, 0, 0, 0, 7, 7, 7);
        compared++;
        if (rbusy !== 2'b00 || rdata[63:0] !== 64'h77) begin
            mismatched++;
            $display("FAIL busy_clear_bypass got %b/%h expected 00/77", rbusy, rdata[63:0]);
        end
        compared++;
        if (rbusy2 !== 3'b111) begin
            mismatched++;
            $display("FAIL busy_clear_nobypass got %b expected 111", rbusy2);
        end
        step();
        apply(0, 0, 0, 0, 0, 0, 0, 7, 7, 7);
        compared++;
        if (rbusy !== 2'b00 || rbusy2 !== 3'b000) begin
            mismatched++;
            $display("FAIL busy_cycle_n4 got %b/%b expected 00/000", rbusy, rbusy2);
        end
        step();
    endtask

    task automatic test_set_clear_flush();
        apply(0, 1, 9, 64'h1234, 1, 9, 0, 9, 9, 9);
        step();
        apply(0, 0, 0, 0, 0, 0, 0, 9, 9, 9);
        compared++;
        if (rdata[63:0] !== 64'h1234 || rbusy !== 2'b11) begin
            mismatched++;
            $display("FAIL set_wins got %h/%b expected 1234/11", rdata[63:0], rbusy);
        end
        compared++;
        if (rdata2[31:0] !== 32'h1234 || rbusy2 !== 3'b111) begin
            mismatched++;
            $display("FAIL set_wins_narrow got %h/%b expected 1234/111", rdata2[31:0], rbusy2);
        end
        step();
        apply(0, 0, 0, 0, 1, 3, 0, 3, 4, 3);
        step();
        apply(0, 0, 0, 0, 1, 4, 0, 3, 4, 3);
        step();
        apply(0, 1, 6, 64'h66, 1, 5, 1, 3, 4, 5);
        compared++;
        if (rbusy !== 2'b11 || rbusy2 !== 3'b011) begin
            mismatched++;
            $display("FAIL flush_before got %b/%b expected 11/011", rbusy, rbusy2);
        end
        step();
        apply(0, 0, 0, 0, 0, 0, 0, 3, 4, 5);
        compared++;
        if (rbusy !== 2'b00 || rbusy2 !== 3'b000) begin
            mismatched++;
            $display("FAIL flush_after got %b/%b expected 00/000", rbusy, rbusy2);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 5, 6, 9);
        compared++;
        if (rbusy !== 2'b00 || rdata[127:64] !== 64'h66 || rbusy2 !== 3'b000) begin
            mismatched++;
            $display("FAIL flush_priority got %b/%h/%b expected 00/66/000", rbusy, rdata[127:64], rbusy2);
        end
        step();
    endtask

    task automatic test_async_reset();
        apply(0, 1, 10, 64'hAA, 1, 10, 0, 10, 10, 10);
        step();
        apply(0, 0, 0, 0, 0, 0, 0, 10, 10, 10);
        compared++;
        if (rdata !== {2{64'hAA}} || rbusy !== 2'b11 || rdata2 !== {3{32'hAA}} || rbusy2 !== 3'b111) begin
            mismatched++;
            $display("FAIL pre_reset got %h/%b %h/%b expected AA busy", rdata, rbusy, rdata2, rbusy2);
        end
        #1;
        reset = 1'b1;
        we    = 1'b1;
        waddr = 10;
        wdata = 64'h55;
        #1;
        compared++;
        if (rdata !== '0 || rbusy !== '0 || rdata2 !== '0 || rbusy2 !== '0) begin
            mismatched++;
            $display("FAIL async_reset got %h/%b %h/%b expected all 0", rdata, rbusy, rdata2, rbusy2);
        end
        step();
        #2;
        reset = 1'b0;
        we    = 1'b0;
        #1;
        compared++;
        if (rdata !== '0 || rbusy !== '0 || rdata2 !== '0 || rbusy2 !== '0) begin
            mismatched++;
            $display("FAIL after_reset got %h/%b %h/%b expected all 0", rdata, rbusy, rdata2, rbusy2);
        end
        step();
    endtask

    task automatic test_random();
        logic [4:0]  ra [3];
        logic [4:0]  a;
        logic [3:0]  a2;
        logic [63:0] ed;
        logic [31:0] ed2;
        logic        eb;
        logic        eb2;
        logic [4:0]  wa;
        for (int n = 0; n < 400; n++) begin
            wa = 5'($urandom_range(0, 31));
            for (int p = 0; p < 3; p++)
                ra[p] = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            apply($urandom_range(0, 59) == 0, 1'($urandom), wa, {$urandom, $urandom},
                  1'($urandom), 5'($urandom_range(0, 31)), $urandom_range(0, 11) == 0,
                  ra[0], ra[1], ra[2]);
            for (int p = 0; p < 2; p++) begin
                a = ra[p];
                if (reset || a == 0)         ed = '0;
                else if (we && waddr == a)   ed = wdata;
                else                         ed = m_regs[a];
                eb = !reset && (a != 0) && m_busy[a] && !(we && waddr == a);
                compared++;
                if (rdata[p*64 +: 64] !== ed || rbusy[p] !== eb) begin
                    mismatched++;
                    $display("FAIL random n=%0d port=%0d raddr=%0d got %h/%b expected %h/%b",
                             n, p, a, rdata[p*64 +: 64], rbusy[p], ed, eb);
                end
            end
            for (int p = 0; p < 3; p++) begin
                a2  = ra[p][3:0];
                ed2 = (reset || a2 == 0) ? 32'h0 : m2_regs[a2];
                eb2 = !reset && (a2 != 0) && m2_busy[a2];
                compared++;
                if (rdata2[p*32 +: 32] !== ed2 || rbusy2[p] !== eb2) begin
                    mismatched++;
                    $display("FAIL random_narrow n=%0d port=%0d raddr=%0d got %h/%b expected %h/%b",
                             n, p, a2, rdata2[p*32 +: 32], rbusy2[p], ed2, eb2);
                end
            end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
        for (int i = 0; i < 16; i++) begin m2_regs[i] = '0; m2_busy[i] = 1'b0; end
        raddr2 = '0;
        @(negedge clk);
        test_reset();
        test_bypass();
        test_zero();
        test_busy_latency();
        test_set_clear_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
